// File: rtl/i2cmb_ctrl_pkg.sv
// Shared definitions for the I2CMB command sequencer: register offsets,
// command codes, completion codes, FSM states and Wishbone request helpers.
package i2cmb_ctrl_pkg;

  // I2CMB register offsets
  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  // CSR values: enable core with interrupts, or shut it down after a hang
  localparam logic [7:0] CSR_ENABLE  = 8'hC0;
  localparam logic [7:0] CSR_DISABLE = 8'h00;

  // CMDR command codes
  localparam logic [2:0] CMD_WRITE    = 3'b001;
  localparam logic [2:0] CMD_READ_ACK = 3'b010;
  localparam logic [2:0] CMD_READ_NAK = 3'b011;
  localparam logic [2:0] CMD_START    = 3'b100;
  localparam logic [2:0] CMD_STOP     = 3'b101;
  localparam logic [2:0] CMD_SET_BUS  = 3'b110;

  // CMDR status bit positions on read-back
  localparam int BIT_NAK = 6;
  localparam int BIT_AL  = 5;
  localparam int BIT_ERR = 4;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NAK      = 3'd1,
    ST_ARB_LOST = 3'd2,
    ST_CORE_ERR = 3'd3,
    ST_TIMEOUT  = 3'd4,
    ST_ERR_LEN  = 3'd5
  } status_t;

  typedef enum logic [3:0] {
    IDLE, ENABLE, DPR_WR, CMD_WR, WAIT_IRQ, CMDR_RD, DPR_RD, WDATA_WAIT, DONE
  } state_t;

  // Which step of the transfer the current command belongs to
  typedef enum logic [2:0] {
    PH_BUS, PH_START, PH_ADDR, PH_DATA, PH_READ, PH_STOP
  } phase_t;

  typedef struct packed {
    logic [1:0] adr;
    logic [7:0] dat;
    logic       we;
  } wb_req_t;

  function automatic wb_req_t wb_wr(input logic [1:0] adr, input logic [7:0] dat);
    wb_req_t r;
    r.adr = adr;
    r.dat = dat;
    r.we  = 1'b1;
    return r;
  endfunction

  function automatic wb_req_t wb_rd(input logic [1:0] adr);
    wb_req_t r;
    r.adr = adr;
    r.dat = 8'h00;
    r.we  = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] cmdr_val(input logic [2:0] cmd);
    return {5'd0, cmd};
  endfunction

endpackage

// File: rtl/i2cmb_wb_master_port.sv
// Single-access Wishbone master: one read or write per start_i pulse.
// Latency: cyc/stb one cycle after start_i; done_o one cycle after ack sampled.
// Backpressure: holds cyc/stb until wb_ack_i; start_i ignored while busy.
module i2cmb_wb_master_port (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  input  logic       we_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  logic       stb_q;
  logic       done_q;
  logic [1:0] adr_q;
  logic [7:0] dat_q;
  logic       we_q;
  logic [7:0] rdata_q;

  // Launch on start, hold until ack, then drop strobe and pulse done
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= 2'd0;
      dat_q   <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (stb_q) begin
        if (wb_ack_i) begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          rdata_q <= wb_dat_i;
        end
      end else if (start_i) begin
        stb_q <= 1'b1;
        adr_q <= adr_i;
        dat_q <= dat_i;
        we_q  <= we_i;
      end
    end
  end

  assign wb_cyc_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Turns one byte-transfer request into the I2CMB command sequence over Wishbone.
// Latency: several Wishbone accesses plus irq waits per command; done_o pulses at the end.
// Backpressure: req_ready_o low while busy; wdata_valid_i low stalls indefinitely.
module i2cmb_cmd_sequencer
  import i2cmb_ctrl_pkg::*;
#(
  parameter int IRQ_TIMEOUT = 50000,
  parameter int MAX_LEN     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_bus_i,
  input  logic [6:0] req_addr_i,
  input  logic       req_rd_i,
  input  logic [4:0] req_len_i,
  input  logic [7:0] wdata_i,
  input  logic       wdata_valid_i,
  output logic       wdata_ready_o,
  output logic [7:0] rdata_o,
  output logic       rdata_valid_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i,
  input  logic       irq_i
);

  state_t      state_q;
  phase_t      phase_q;
  status_t     status_q;
  status_t     stop_status_q;
  logic        ready_q;
  logic        done_q;
  logic        rvld_q;
  logic [7:0]  rdata_q;
  logic        enabled_q;
  logic        tmo_mode_q;
  logic [4:0]  cnt_q;
  logic [31:0] tmo_q;
  logic [3:0]  bus_q;
  logic [6:0]  addr_q;
  logic        rd_q;
  logic        start_q;
  wb_req_t     wreq_q;

  logic        wb_done;
  logic [7:0]  wb_rdata;

  i2cmb_wb_master_port u_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_q),
    .adr_i    (wreq_q.adr),
    .dat_i    (wreq_q.dat),
    .we_i     (wreq_q.we),
    .done_o   (wb_done),
    .rdata_o  (wb_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

  // Sequencer FSM: every Wishbone access is launched on the transition into its state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      phase_q       <= PH_BUS;
      status_q      <= ST_OK;
      stop_status_q <= ST_OK;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      rvld_q        <= 1'b0;
      rdata_q       <= 8'd0;
      enabled_q     <= 1'b0;
      tmo_mode_q    <= 1'b0;
      cnt_q         <= 5'd0;
      tmo_q         <= 32'd0;
      bus_q         <= 4'd0;
      addr_q        <= 7'd0;
      rd_q          <= 1'b0;
      start_q       <= 1'b0;
      wreq_q        <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rvld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_q && req_valid_i) begin
            ready_q <= 1'b0;
            bus_q   <= req_bus_i;
            addr_q  <= req_addr_i;
            rd_q    <= req_rd_i;
            cnt_q   <= req_len_i;
            phase_q <= PH_BUS;
            if (req_len_i == 5'd0 || 32'(req_len_i) > MAX_LEN) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_ERR_LEN;
            end else if (!enabled_q) begin
              state_q    <= ENABLE;
              tmo_mode_q <= 1'b0;
              start_q    <= 1'b1;
              wreq_q     <= wb_wr(ADR_CSR, CSR_ENABLE);
            end else begin
              state_q <= DPR_WR;
              start_q <= 1'b1;
              wreq_q  <= wb_wr(ADR_DPR, {4'd0, req_bus_i});
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ENABLE: begin
          if (wb_done) begin
            if (tmo_mode_q) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_TIMEOUT;
            end else begin
              enabled_q <= 1'b1;
              state_q   <= DPR_WR;
              start_q   <= 1'b1;
              wreq_q    <= wb_wr(ADR_DPR, {4'd0, bus_q});
            end
          end
        end
        DPR_WR: begin
          if (wb_done) begin
            state_q <= CMD_WR;
            start_q <= 1'b1;
            wreq_q  <= wb_wr(ADR_CMDR,
                             cmdr_val((phase_q == PH_BUS) ? CMD_SET_BUS : CMD_WRITE));
          end
        end
        CMD_WR: begin
          if (wb_done) begin
            state_q <= WAIT_IRQ;
            tmo_q   <= 32'd0;
          end
        end
        WAIT_IRQ: begin
          if (irq_i) begin
            state_q <= CMDR_RD;
            start_q <= 1'b1;
            wreq_q  <= wb_rd(ADR_CMDR);
          end else if (tmo_q == 32'(IRQ_TIMEOUT - 1)) begin
            // Core is hung: disable it so the next request re-enables from scratch
            state_q    <= ENABLE;
            tmo_mode_q <= 1'b1;
            enabled_q  <= 1'b0;
            start_q    <= 1'b1;
            wreq_q     <= wb_wr(ADR_CSR, CSR_DISABLE);
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        CMDR_RD: begin
          if (wb_done) begin
            if (wb_rdata[BIT_AL]) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_ARB_LOST;
            end else if (wb_rdata[BIT_ERR]) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= ST_CORE_ERR;
            end else if (phase_q == PH_STOP) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              status_q <= stop_status_q;
            end else if (wb_rdata[BIT_NAK] && (phase_q == PH_ADDR || phase_q == PH_DATA)) begin
              stop_status_q <= ST_NAK;
              phase_q       <= PH_STOP;
              state_q       <= CMD_WR;
              start_q       <= 1'b1;
              wreq_q        <= wb_wr(ADR_CMDR, cmdr_val(CMD_STOP));
            end else begin
              case (phase_q)
                PH_BUS: begin
                  phase_q <= PH_START;
                  state_q <= CMD_WR;
                  start_q <= 1'b1;
                  wreq_q  <= wb_wr(ADR_CMDR, cmdr_val(CMD_START));
                end
                PH_START: begin
                  phase_q <= PH_ADDR;
                  state_q <= DPR_WR;
                  start_q <= 1'b1;
                  wreq_q  <= wb_wr(ADR_DPR, {addr_q, rd_q});
                end
                PH_READ: begin
                  state_q <= DPR_RD;
                  start_q <= 1'b1;
                  wreq_q  <= wb_rd(ADR_DPR);
                end
                default: begin
                  // Address or data byte accepted: move to the next byte or finish
                  if (cnt_q == 5'd0) begin
                    stop_status_q <= ST_OK;
                    phase_q       <= PH_STOP;
                    state_q       <= CMD_WR;
                    start_q       <= 1'b1;
                    wreq_q        <= wb_wr(ADR_CMDR, cmdr_val(CMD_STOP));
                  end else if (rd_q) begin
                    phase_q <= PH_READ;
                    state_q <= CMD_WR;
                    start_q <= 1'b1;
                    wreq_q  <= wb_wr(ADR_CMDR,
                                     cmdr_val((cnt_q == 5'd1) ? CMD_READ_NAK : CMD_READ_ACK));
                  end else begin
                    phase_q <= PH_DATA;
                    state_q <= WDATA_WAIT;
                  end
                end
              endcase
            end
          end
        end
        DPR_RD: begin
          if (wb_done) begin
            rdata_q <= wb_rdata;
            rvld_q  <= 1'b1;
            cnt_q   <= cnt_q - 5'd1;
            state_q <= CMD_WR;
            start_q <= 1'b1;
            if (cnt_q == 5'd1) begin
              stop_status_q <= ST_OK;
              phase_q       <= PH_STOP;
              wreq_q        <= wb_wr(ADR_CMDR, cmdr_val(CMD_STOP));
            end else begin
              wreq_q <= wb_wr(ADR_CMDR,
                              cmdr_val((cnt_q == 5'd2) ? CMD_READ_NAK : CMD_READ_ACK));
            end
          end
        end
        WDATA_WAIT: begin
          if (wdata_valid_i) begin
            cnt_q   <= cnt_q - 5'd1;
            state_q <= DPR_WR;
            start_q <= 1'b1;
            wreq_q  <= wb_wr(ADR_DPR, wdata_i);
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte handshake decodes straight from the state register so it lasts exactly one cycle
  assign wdata_ready_o = (state_q == WDATA_WAIT) && wdata_valid_i;
  assign req_ready_o   = ready_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvld_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Scoreboard bench for i2cmb_cmd_sequencer with a behavioural I2CMB core model.
module tb_i2cmb_cmd_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [3:0] req_bus_i = '0;
  logic [6:0] req_addr_i = '0;
  logic       req_rd_i = 1'b0;
  logic [4:0] req_len_i = '0;
  logic [7:0] wdata_i = '0;
  logic       wdata_valid_i = 1'b0;
  logic       wdata_ready_o;
  logic [7:0] rdata_o;
  logic       rdata_valid_o;
  logic       done_o;
  logic [2:0] status_o;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic       wb_we_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_ack_i = 1'b0;
  logic       irq_i = 1'b0;

  i2cmb_cmd_sequencer #(.IRQ_TIMEOUT(100), .MAX_LEN(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_rd_i(req_rd_i), .req_len_i(req_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .status_o(status_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .irq_i(irq_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [1:0] adr; logic we; logic [7:0] dat; } acc_t;

  acc_t       exp_wb[$];
  logic [7:0] exp_rd[$];
  logic [2:0] exp_done[$];
  logic [7:0] wq[$];      // write bytes offered on wdata_*
  logic [7:0] rq[$];      // bytes the core model returns on DPR reads

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int cyc = 0;
  int last_cmdr_cyc = 0;
  bit mon_wb_en = 1'b1;

  // core model controls
  bit irq_hold = 1'b0;
  bit nak_on_addr = 1'b0;
  bit al_on_start = 1'b0;
  logic [7:0] cmdr_resp = 8'h80;
  int irq_cnt = 0;
  int wr_idx = 0;

  always @(posedge clk_i) cyc++;

  // I2CMB core model: acks each access once, raises irq a few cycles after a command
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      wb_ack_i = 1'b0;
      irq_i    = 1'b0;
      irq_cnt  = 0;
    end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      wb_ack_i = 1'b1;
      if (wb_we_o) begin
        if (wb_adr_o == 2'd2) begin
          cmdr_resp = 8'h80;
          if (wb_dat_o[2:0] == 3'b100) begin
            wr_idx = 0;
            if (al_on_start) cmdr_resp = 8'h20;
          end
          if (wb_dat_o[2:0] == 3'b001) begin
            if (nak_on_addr && wr_idx == 0) cmdr_resp = 8'hC0;
            wr_idx++;
          end
          irq_cnt = irq_hold ? 0 : 3;
        end
      end else if (wb_adr_o == 2'd2) begin
        wb_dat_i = cmdr_resp;
        irq_i    = 1'b0;
      end else if (wb_adr_o == 2'd1) begin
        wb_dat_i = (rq.size() > 0) ? rq.pop_front() : 8'hEE;
      end else begin
        wb_dat_i = 8'h00;
      end
    end else begin
      wb_ack_i = 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) irq_i = 1'b1;
      end
    end
  end

  // Write-byte source: presents the head of wq, advances after each handshake
  initial begin
    forever begin
      @(negedge clk_i);
      if (wdata_valid_i && wdata_ready_o) begin
        @(posedge clk_i);
        #1;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      wdata_valid_i = (wq.size() > 0);
      wdata_i       = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // Monitor: compare every DUT-presented output event against the scoreboard queues
  always @(negedge clk_i) begin
    if (mon_wb_en && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      acc_t e;
      checks++;
      if (exp_wb.size() == 0) begin
        errors++;
        $display("FAIL wb_access: unexpected adr=%0d we=%0b dat=%02h, expected none", wb_adr_o, wb_we_o, wb_dat_o);
      end else begin
        e = exp_wb.pop_front();
        if (wb_adr_o != e.adr || wb_we_o != e.we || (e.we && wb_dat_o != e.dat)) begin
          errors++;
          $display("FAIL wb_access: got adr=%0d we=%0b dat=%02h, expected adr=%0d we=%0b dat=%02h",
                   wb_adr_o, wb_we_o, wb_dat_o, e.adr, e.we, e.dat);
        end
      end
      if (wb_we_o && wb_adr_o == 2'd2) last_cmdr_cyc = cyc;
      if (wb_we_o && wb_adr_o == 2'd0 && wb_dat_o == 8'h00) begin
        // 100 idle-irq cycles plus the few-cycle ack-to-strobe pipeline
        checks++;
        if (cyc - last_cmdr_cyc < 100 || cyc - last_cmdr_cyc > 105) begin
          errors++;
          $display("FAIL timeout_delay: CSR 00 came %0d cycles after CMDR write, expected 100..105",
                   cyc - last_cmdr_cyc);
        end
      end
    end
    if (rdata_valid_o) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rdata: unexpected strobe with %02h", rdata_o);
      end else begin
        logic [7:0] b;
        b = exp_rd.pop_front();
        if (rdata_o != b) begin
          errors++;
          $display("FAIL rdata: got %02h, expected %02h", rdata_o, b);
        end
      end
    end
    if (done_o) begin
      done_seen++;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_status: unexpected done with status %0d", status_o);
      end else begin
        logic [2:0] s;
        s = exp_done.pop_front();
        if (status_o != s) begin
          errors++;
          $display("FAIL done_status: got %0d, expected %0d", status_o, s);
        end
      end
    end
  end

  task automatic ew(input logic [1:0] adr, input logic [7:0] dat);
    exp_wb.push_back({adr, 1'b1, dat});
  endtask

  task automatic er(input logic [1:0] adr);
    exp_wb.push_back({adr, 1'b0, 8'h00});
  endtask

  // CMDR write followed by the CMDR status read-back
  task automatic xcmd(input logic [7:0] c);
    ew(2'd2, c);
    er(2'd2);
  endtask

  task automatic send_req(input logic [3:0] bus, input logic [6:0] addr, input logic rd, input logic [4:0] len);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    req_bus_i   = bus;
    req_addr_i  = addr;
    req_rd_i    = rd;
    req_len_i   = len;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic run(input logic [3:0] bus, input logic [6:0] addr, input logic rd, input logic [4:0] len);
    int target;
    int n;
    target = done_seen + 1;
    send_req(bus, addr, rd, len);
    n = 0;
    while (done_seen < target && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (done_seen < target) begin
      errors++;
      $display("FAIL done_wait: no done_o within %0d cycles, expected one", n);
    end
  endtask

  task automatic check_drained(input string name);
    @(negedge clk_i);
    checks++;
    if (exp_wb.size() + exp_rd.size() + exp_done.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: leftover wb=%0d rd=%0d done=%0d, expected 0", name,
               exp_wb.size(), exp_rd.size(), exp_done.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [32:0] v;
    v = {req_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, done_o, status_o,
         wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, expected all zero", name, v);
    end
  endtask

  task automatic check_ready(input string name);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: req_ready_o=%b, expected 1", name, req_ready_o);
    end
  endtask

  initial begin
    int n;
    #2;
    check_outputs_zero("reset_outputs");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_ready("ready_after_reset");

    // Write bus 2, addr 22, AA/BB/CC, all ACKed; first request enables the core
    wq.push_back(8'hAA); wq.push_back(8'hBB); wq.push_back(8'hCC);
    ew(2'd0, 8'hC0); ew(2'd1, 8'h02); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h44); xcmd(8'h01);
    ew(2'd1, 8'hAA); xcmd(8'h01);
    ew(2'd1, 8'hBB); xcmd(8'h01);
    ew(2'd1, 8'hCC); xcmd(8'h01);
    xcmd(8'h05);
    exp_done.push_back(3'd0);
    run(4'd2, 7'h22, 1'b0, 5'd3);
    check_drained("write");

    // Read 2 bytes from addr 22: READ_ACK then READ_NAK, bytes 11 then 22
    rq.push_back(8'h11); rq.push_back(8'h22);
    ew(2'd1, 8'h02); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h45); xcmd(8'h01);
    xcmd(8'h02); er(2'd1);
    xcmd(8'h03); er(2'd1);
    xcmd(8'h05);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    exp_done.push_back(3'd0);
    run(4'd2, 7'h22, 1'b1, 5'd2);
    check_drained("read");

    // Address NAK: STOP, no data bytes, status NAK
    nak_on_addr = 1'b1;
    ew(2'd1, 8'h02); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h44); xcmd(8'h01);
    xcmd(8'h05);
    exp_done.push_back(3'd1);
    run(4'd2, 7'h22, 1'b0, 5'd2);
    nak_on_addr = 1'b0;
    check_drained("addr_nak");

    // Arbitration lost on START: no STOP, status ARB_LOST
    al_on_start = 1'b1;
    ew(2'd1, 8'h02); xcmd(8'h06); xcmd(8'h04);
    exp_done.push_back(3'd2);
    run(4'd2, 7'h22, 1'b0, 5'd1);
    al_on_start = 1'b0;
    check_drained("arb_lost");

    // Next request after AL proceeds normally: 1-byte read from addr 10 on bus 1
    rq.push_back(8'h5A);
    ew(2'd1, 8'h01); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h21); xcmd(8'h01);
    xcmd(8'h03); er(2'd1);
    xcmd(8'h05);
    exp_rd.push_back(8'h5A);
    exp_done.push_back(3'd0);
    run(4'd1, 7'h10, 1'b1, 5'd1);
    check_drained("after_al");

    // irq never arrives after SET_BUS: CSR 00 then TIMEOUT
    irq_hold = 1'b1;
    ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd0, 8'h00);
    exp_done.push_back(3'd4);
    run(4'd0, 7'h50, 1'b0, 5'd1);
    irq_hold = 1'b0;
    check_drained("timeout");

    // Following request must re-enable the core
    wq.push_back(8'h77);
    ew(2'd0, 8'hC0); ew(2'd1, 8'h03); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h1E); xcmd(8'h01);
    ew(2'd1, 8'h77); xcmd(8'h01);
    xcmd(8'h05);
    exp_done.push_back(3'd0);
    run(4'd3, 7'h0F, 1'b0, 5'd1);
    check_drained("reenable");

    // Write byte withheld for 200 cycles, longer than the irq timeout: must not time out
    ew(2'd1, 8'h00); xcmd(8'h06); xcmd(8'h04);
    ew(2'd1, 8'h02); xcmd(8'h01);
    ew(2'd1, 8'h3C); xcmd(8'h01);
    xcmd(8'h05);
    exp_done.push_back(3'd0);
    fork
      run(4'd0, 7'h01, 1'b0, 5'd1);
      begin
        repeat (200) @(negedge clk_i);
        wq.push_back(8'h3C);
      end
    join
    check_drained("wdata_stall");

    // Length 17 exceeds MAX_LEN
    exp_done.push_back(3'd5);
    run(4'd0, 7'h01, 1'b0, 5'd17);
    check_drained("len_17");

    // Reset while a strobe is outstanding: outputs drop before any clock edge
    mon_wb_en = 1'b0;
    send_req(4'd1, 7'h33, 1'b0, 5'd1);
    n = 0;
    while (!wb_stb_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!wb_stb_o) begin
      errors++;
      $display("FAIL stb_wait: wb_stb_o=%b after %0d cycles, expected 1", wb_stb_o, n);
    end
    #1;
    rst_i = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    exp_wb.delete(); exp_rd.delete(); exp_done.delete(); wq.delete(); rq.delete();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    mon_wb_en = 1'b1;
    @(posedge clk_i);
    #1;
    check_ready("ready_after_midreset");

    // Zero length after reset: ERR_LEN on the cycle after acceptance, no bus traffic
    exp_done.push_back(3'd5);
    send_req(4'd0, 7'h01, 1'b0, 5'd0);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL errlen_timing: done_o=%b one cycle after accept, expected 1", done_o);
    end
    repeat (20) @(negedge clk_i);
    check_drained("len_0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
